run_length_detector: RTL

//  Parametrised detector for runs of identical bits on serial input w; generalises the fixed 4-zeros/4-ones FSM.
//  Run length threshold is runtime-selectable up to MAX_RUN. Tracks current run bit and length, and flags hits.

---
 rtl/run_length_detector_if.sv | 29 ++
 rtl/run_length_detector.sv | 102 ++++++++++
 2 files changed

// File: rtl/run_length_detector_if.sv
// rtl/run_length_detector_if.sv - sample/threshold inputs and run/hit status outputs of run_length_detector
interface run_length_detector_if #(
  parameter int MAX_RUN = 16,
  parameter int CNT_W   = 8
);
  localparam int TH_W = $clog2(MAX_RUN + 1);

  logic             w;
  logic             valid;
  logic [TH_W-1:0]  thresh;
  logic             sclr;
  logic             z;
  logic             hit_pulse;
  logic             run_bit;
  logic [TH_W-1:0]  run_cnt;
  logic [CNT_W-1:0] hit_cnt;
  logic [1:0]       state;
  logic             sticky;

  modport master (
    output w, valid, thresh, sclr,
    input  z, hit_pulse, run_bit, run_cnt, hit_cnt, state, sticky
  );

  modport slave (
    input  w, valid, thresh, sclr,
    output z, hit_pulse, run_bit, run_cnt, hit_cnt, state, sticky
  );
endinterface

// File: rtl/run_length_detector.sv
// rtl/run_length_detector.sv - runtime-threshold detector for runs of identical bits on a serial input
// Optional latched hit flag enabled by defining RUN_DET_STICKY_EN.
module run_length_detector #(
  parameter int MAX_RUN = 16,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  aclr,
  run_length_detector_if.slave  bus
);
  localparam int TH_W = $clog2(MAX_RUN + 1);
  localparam logic [TH_W-1:0] MAX_CNT = TH_W'(MAX_RUN);
  localparam logic [TH_W-1:0] ONE_CNT = TH_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HIT  = 2'b10
  } state_t;

  state_t           state_q, state_n;
  logic             z_q, hit_pulse_q, run_bit_q;
  logic             run_bit_n, pulse_n, same;
  logic [TH_W-1:0]  run_cnt_q, run_cnt_n, cnt_inc, eff_th;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_n;

  always_comb begin
    state_n   = state_q;
    run_bit_n = run_bit_q;
    run_cnt_n = run_cnt_q;
    pulse_n   = 1'b0;
    hit_cnt_n = hit_cnt_q;

    if (bus.thresh == '0)
      eff_th = ONE_CNT;
    else if (bus.thresh > MAX_CNT)
      eff_th = MAX_CNT;
    else
      eff_th = bus.thresh;

    // The undefined encoding 2'b11 counts as IDLE, so it never extends a run.
    same    = ((state_q == RUN) || (state_q == HIT)) && (bus.w == run_bit_q);
    cnt_inc = (run_cnt_q >= MAX_CNT) ? MAX_CNT : run_cnt_q + ONE_CNT;

    if (bus.valid) begin
      run_bit_n = same ? run_bit_q : bus.w;
      run_cnt_n = same ? cnt_inc : ONE_CNT;
      state_n   = (run_cnt_n >= eff_th) ? HIT : RUN;
      // Rising-edge-only hit: a run held at saturation does not re-trigger.
      pulse_n   = (run_cnt_n == eff_th) && (!same || (run_cnt_q < eff_th));
    end else if ((state_q != RUN) && (state_q != HIT)) begin
      state_n = IDLE;
    end

    if (bus.sclr)
      hit_cnt_n = '0;
    else if (pulse_n && (hit_cnt_q != '1))
      hit_cnt_n = hit_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      state_q     <= IDLE;
      z_q         <= 1'b0;
      hit_pulse_q <= 1'b0;
      run_bit_q   <= 1'b0;
      run_cnt_q   <= '0;
      hit_cnt_q   <= '0;
    end else begin
      state_q     <= state_n;
      z_q         <= (state_n == HIT);
      hit_pulse_q <= pulse_n;
      run_bit_q   <= run_bit_n;
      run_cnt_q   <= run_cnt_n;
      hit_cnt_q   <= hit_cnt_n;
    end
  end

`ifdef RUN_DET_STICKY_EN
  logic sticky_q;

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr)
      sticky_q <= 1'b0;
    else if (bus.sclr)
      sticky_q <= 1'b0;
    else if (pulse_n)
      sticky_q <= 1'b1;
  end

  assign bus.sticky = sticky_q;
`else
  assign bus.sticky = 1'b0;
`endif

  assign bus.z         = z_q;
  assign bus.hit_pulse = hit_pulse_q;
  assign bus.run_bit   = run_bit_q;
  assign bus.run_cnt   = run_cnt_q;
  assign bus.hit_cnt   = hit_cnt_q;
  assign bus.state     = state_q;
endmodule
